// File: rtl/afc_freq_comparator.sv
// AFC frequency comparator: counts divided-VCO ticks over a fixed window and issues fast/slow/freeze codes.
// Optional macro AFC_SETTLE_EN adds a SETTLE state before every measurement window.
module afc_freq_comparator #(
  parameter int CNT_W  = 12,
  parameter int WINDOW = 64,
  parameter int TOL    = 2,
  parameter int SETTLE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vco_tick,
  input  logic [CNT_W-1:0] target_cnt,
  input  logic             done_in,
  output logic [2:0]       comp_out,
  output logic             busy,
  output logic [CNT_W-1:0] meas_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
`ifdef AFC_SETTLE_EN
    S_SETTLE  = 3'd1,
`endif
    S_MEASURE = 3'd2,
    S_DECIDE  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [16:0]    WIN_LAST = 17'(WINDOW - 1);
  localparam logic [CNT_W:0] TOL_X    = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [2:0] C_FAST   = 3'b100;
  localparam logic [2:0] C_SLOW   = 3'b010;
  localparam logic [2:0] C_FREEZE = 3'b001;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [16:0]      win_q, win_d;
  logic [2:0]       comp_q, comp_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic [CNT_W-1:0] cnt_n;
  logic             run_s;
`ifdef AFC_SETTLE_EN
  localparam logic [16:0] SET_LAST = 17'(SETTLE - 1);
  logic [16:0] settle_q, settle_d;
`endif

  // Compare in CNT_W+1 bits so target+TOL cannot wrap; slow is suppressed when target < TOL.
  function automatic logic [2:0] decide(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] t);
    logic [CNT_W:0] c_x;
    logic [CNT_W:0] t_x;
    c_x = {1'b0, c};
    t_x = {1'b0, t};
    if (c_x > t_x + TOL_X) begin
      decide = C_FAST;
    end else if ((t_x >= TOL_X) && (c_x < t_x - TOL_X)) begin
      decide = C_SLOW;
    end else begin
      decide = C_FREEZE;
    end
  endfunction

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    meas_d   = meas_q;
    comp_d   = 3'b000;
    run_s    = 1'b0;
    cnt_n    = (vco_tick && (cnt_q != CNT_MAX)) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
`ifdef AFC_SETTLE_EN
    settle_d = settle_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d = target_cnt;
          run_s    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef AFC_SETTLE_EN
      S_SETTLE: begin
        if (settle_q == SET_LAST) begin
          state_d = S_MEASURE;
          cnt_d   = {CNT_W{1'b0}};
          win_d   = 17'd0;
        end else begin
          settle_d = settle_q + 17'd1;
        end
      end
`endif
      S_MEASURE: begin
        cnt_d = cnt_n;
        if (win_q == WIN_LAST) begin
          state_d = S_DECIDE;
          meas_d  = cnt_n;
          comp_d  = decide(cnt_n, target_q);
        end else begin
          win_d = win_q + 17'd1;
        end
      end
      S_DECIDE: begin
        if (comp_q == C_FREEZE) begin
          state_d = S_DONE;
        end else begin
          run_s = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          target_d = target_cnt;
          run_s    = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every new run or retry enters the settle phase, or the window directly when settle is absent.
    if (run_s) begin
`ifdef AFC_SETTLE_EN
      state_d  = S_SETTLE;
      settle_d = 17'd0;
`else
      state_d  = S_MEASURE;
      cnt_d    = {CNT_W{1'b0}};
      win_d    = 17'd0;
`endif
    end else begin
      state_d = state_d;
    end

    if (done_in && busy_q) begin
      state_d = S_DONE;
      comp_d  = 3'b000;
    end else begin
      comp_d = comp_d;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      target_q <= {CNT_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      win_q    <= 17'd0;
      comp_q   <= 3'b000;
      busy_q   <= 1'b0;
      meas_q   <= {CNT_W{1'b0}};
`ifdef AFC_SETTLE_EN
      settle_q <= 17'd0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      comp_q   <= comp_d;
      busy_q   <= busy_d;
      meas_q   <= meas_d;
`ifdef AFC_SETTLE_EN
      settle_q <= settle_d;
`endif
    end
  end

  assign comp_out = comp_q;
  assign busy     = busy_q;
  assign meas_cnt = meas_q;

endmodule

// File: tb/tb_afc_freq_comparator.sv
// Directed, scoreboard-based bench for afc_freq_comparator (WINDOW=16, TOL=1, SETTLE=4).
module tb_afc_freq_comparator;

  localparam int WINDOW = 16;
  localparam int TOL    = 1;
  localparam int SETTLE = 4;
`ifdef AFC_SETTLE_EN
  localparam int LAT = SETTLE + WINDOW + 1;
`else
  localparam int LAT = WINDOW + 1;
`endif
  localparam int MLO = LAT - WINDOW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        vco_tick = 1'b0;
  logic        done_in = 1'b0;
  logic [11:0] target_cnt = 12'd0;
  logic [2:0]  tgt3 = 3'd0;
  logic [2:0]  comp_out, comp3;
  logic        busy, busy3;
  logic [11:0] meas_cnt;
  logic [2:0]  meas3;

  typedef struct {
    logic [2:0] code;
    int         meas;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int c = 0;
  int tk_per = 0;
  int tk_lo = 0;
  int tk_hi = 0;

  afc_freq_comparator #(.CNT_W(12), .WINDOW(WINDOW), .TOL(TOL), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .vco_tick(vco_tick), .target_cnt(target_cnt),
    .done_in(done_in), .comp_out(comp_out), .busy(busy), .meas_cnt(meas_cnt));

  afc_freq_comparator #(.CNT_W(3), .WINDOW(WINDOW), .TOL(TOL), .SETTLE(SETTLE)) dut3 (
    .clk(clk), .rst(rst), .start(start), .vco_tick(vco_tick), .target_cnt(tgt3),
    .done_in(done_in), .comp_out(comp3), .busy(busy3), .meas_cnt(meas3));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    vco_tick = (tk_per != 0) && (c >= tk_lo) && (c < tk_hi) && ((c % tk_per) == 0);
    @(posedge clk);
    #1;
    c++;
    start = 1'b0;
  endtask

  task automatic stop_run();
    done_in = 1'b1;
    step();
    done_in = 1'b0;
  endtask

  task automatic launch(input int tgt, input int t3, input int per, input int lo, input int hi,
                        input logic [2:0] code, input int meas);
    exp_t e;
    tk_per = per;
    tk_lo = lo;
    tk_hi = hi;
    target_cnt = 12'(tgt);
    tgt3 = 3'(t3);
    start = 1'b1;
    c = 0;
    e.code = code;
    e.meas = meas;
    q.push_back(e);
  endtask

  task automatic expect_next(input logic [2:0] code, input int meas);
    exp_t e;
    e.code = code;
    e.meas = meas;
    q.push_back(e);
  endtask

  task automatic wait_decision(input string tag, input int n0);
    exp_t e;
    int n;
    n = n0;
    do begin
      step();
      n++;
    end while (comp_out == 3'b000 && n < 200);
    e = q.pop_front();
    check({tag, "_latency"}, n, LAT);
    check({tag, "_code"}, int'(comp_out), int'(e.code));
    check({tag, "_meas"}, int'(meas_cnt), e.meas);
  endtask

  initial begin
    int pulses;
    step();
    step();
    rst = 1'b0;
    check("reset_comp", int'(comp_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_meas", int'(meas_cnt), 0);

    // fast: 16 ticks per window against target 8
    launch(8, 0, 1, 0, 100000, 3'b100, 16);
    wait_decision("fast", 0);
    check("fast_busy", int'(busy), 1);
    step();
    check("fast_pulse_width", int'(comp_out), 0);
    check("fast_retry_busy", int'(busy), 1);
    stop_run();
    check("fast_done_busy", int'(busy), 0);
    check("fast_done_comp", int'(comp_out), 0);
    step();
    check("done_hold", int'(busy), 0);

    // slow: 4 ticks per window, repeated window, then forced done
    launch(8, 0, 4, 0, 100000, 3'b010, 4);
    wait_decision("slow1", 0);
    expect_next(3'b010, 4);
    wait_decision("slow2", 0);
    stop_run();
    check("slow_done_busy", int'(busy), 0);
    check("slow_done_comp", int'(comp_out), 0);

    // freeze: 8 ticks; a second start while busy with target 0 must be ignored
    launch(8, 0, 2, 0, 100000, 3'b001, 8);
    step();
    start = 1'b1;
    target_cnt = 12'd0;
    step();
    wait_decision("freeze", 2);
    step();
    check("freeze_done_busy", int'(busy), 0);
    check("freeze_done_comp", int'(comp_out), 0);

    // tolerance boundaries around target 8
    launch(8, 0, 1, MLO, MLO + 9, 3'b001, 9);
    wait_decision("upper_edge", 0);
    step();
    launch(8, 0, 1, MLO, MLO + 10, 3'b100, 10);
    wait_decision("above_upper", 0);
    stop_run();
    launch(8, 0, 1, MLO, MLO + 7, 3'b001, 7);
    wait_decision("lower_edge", 0);
    step();
    launch(3, 0, 1, LAT - 1, LAT, 3'b010, 1);
    wait_decision("last_cycle_tick", 0);
    stop_run();
    launch(3, 0, 1, MLO, MLO + 1, 3'b010, 1);
    wait_decision("first_cycle_tick", 0);
    stop_run();
    launch(8, 0, 1, MLO - 2, MLO + 2, 3'b010, 2);
    wait_decision("pre_window_ticks", 0);
    stop_run();
    launch(8, 0, 1, MLO, MLO + 6, 3'b010, 6);
    wait_decision("below_lower", 0);
    stop_run();

    // reset in measure cycle 10 beats start/done_in/tick and discards the count
    launch(8, 0, 1, 0, 100000, 3'b000, 0);
    q.delete();
    while (c < MLO + 10) step();
    rst = 1'b1;
    start = 1'b1;
    done_in = 1'b1;
    step();
    rst = 1'b0;
    done_in = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_comp", int'(comp_out), 0);
    check("midrst_meas", int'(meas_cnt), 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (comp_out != 3'b000 || busy) pulses++;
    end
    check("midrst_quiet", pulses, 0);

    // saturation on the 3-bit instance, then zero target with no ticks
    launch(8, 5, 1, 0, 100000, 3'b100, 16);
    wait_decision("sat_wide", 0);
    check("sat3_code", int'(comp3), 4);
    check("sat3_meas", int'(meas3), 7);
    stop_run();
    launch(0, 0, 0, 0, 0, 3'b001, 0);
    wait_decision("zero_target", 0);
    check("zero3_code", int'(comp3), 1);
    check("zero3_meas", int'(meas3), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
